mult_share_arbiter: RTL
=======================

Name: mult_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sequential signed shift-add multiplier among NREQ requesters. It latches the winning requester's operands, issues a one-cycle start to the multiplier and waits for the multiplier's ready. It then returns the 2*NB-bit signed product to the winner with a one-cycle done pulse. The block sits between the requesting datapath blocks and the multiplier, which it drives through the mul_* ports.

Parameters:
NB, 32, operand width; must equal the multiplier's nb.
NREQ, 4, number of requesters (2..8).
TMO, NB+4, cycles allowed in WAIT for mul_ready before timeout.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request level; held high until that requester's done
req_a  in  NREQ*NB  packed signed multiplicands; requester i at bits [i*NB +: NB]
req_b  in  NREQ*NB  packed signed multipliers, same packing
gnt  out  NREQ  one-hot registered grant; high from grant through done cycle
done  out  NREQ  one-hot, one-cycle completion pulse
result  out  2*NB  signed product; valid only while done is non-zero; holds last value otherwise
busy  out  1  high in any state other than IDLE
err  out  1  sticky timeout flag; cleared only by rst
mul_start  out  1  start pulse to multiplier
mul_a  out  NB  latched multiplicand to multiplier
mul_b  out  NB  latched multiplier operand to multiplier
mul_product  in  2*NB  multiplier product
mul_ready  in  1  multiplier ready (combinational, counter==NB)

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - gnt, done, result, mul_start, mul_a, mul_b, err, busy all go to 0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - rst overrides every other input in the same cycle.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - If req is non-zero, select the first set bit scanning from pointer+1 upward with wrap.
  - Register gnt (one-hot) and latch that requester's req_a/req_b into mul_a/mul_b.
  - Set pointer to the winner and go to START.
  - Otherwise stay in IDLE.
- START:
  - mul_start=1 for exactly this cycle; go to WAIT and clear the timeout counter.
  - mul_ready is ignored in this cycle, because it may be stale-high from the previous operation.
- WAIT:
  - mul_start=0; the timeout counter increments each cycle.
  - On mul_ready=1: capture mul_product into result, set done=gnt, go to DONE.
  - If the counter reaches TMO first: set err=1, result=0, done=gnt, go to DONE.
- DONE:
  - done is high for this single cycle only.
  - At the edge, clear gnt and done and return to IDLE.
  - A new grant can be made at the next IDLE edge; there is no back-to-back start without passing through IDLE.
- Latency: with req sampled at IDLE edge E0, mul_start is high in cycle E0..E1 and the multiplier loads at E1. Ready is high after E(NB+1) and is sampled at E(NB+2). done is high in cycle E(NB+2)..E(NB+3). Throughput is one product per NB+3 cycles.
- Operands are latched at grant; later changes on req_a/req_b do not affect the operation in flight.
- Dropping req after grant does not abort; the operation completes and done still pulses.
- A requester must not re-raise req in its own done cycle expecting a new grant before IDLE.
- Fairness: a requester holding req continuously is granted within NREQ-1 other operations.
- Reset mid-operation: the controller returns to IDLE with no done pulse. The multiplier may keep running; the next mul_start reloads it.
- Widths:
  - result is 2*NB signed and is passed through unmodified.
  - gnt and done are never multi-hot.
  - mul_start is never high in two consecutive cycles.

Test Plan:
- NB=8, single request: req=0001, a=-3, b=5 -> mul_start one cycle after grant; done=0001 exactly 10 cycles (NB+2) after the request-sampling edge; result=-15 (16'hFFF1).
- Simultaneous req=1111 held: grants in order 0,1,2,3,0. With a_i=i+1 and b_i=-2, results are -2, -4, -6, -8, each done pulse one-hot, spaced 11 cycles apart.
- Corner values, NB=8: a=-128, b=-128 -> result=16384; a=127, b=-128 -> -16256; a=0, b=-1 -> 0.
- Operand change after grant: grant req 2 with a=7, b=9, then change req_a/req_b to 0 -> result=63.
- Timeout: hold mul_ready=0 in the multiplier model -> after TMO cycles in WAIT, err=1, result=0, done pulses for the granted requester; err stays 1 until rst.
- Reset in WAIT: assert rst for one cycle mid-multiply -> gnt, busy and done go to 0 with no done pulse. A re-request then completes correctly and requester 0 is served first.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer that shares one sequential signed
// multiplier among NREQ requesters.  The winner's operands are latched at
// grant, the multiplier gets a one-cycle start, and the product is returned
// to the winner with a one-cycle done pulse.
module mult_share_arbiter #(
  parameter int unsigned NB   = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = NB + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*NB-1:0]     req_a,
  input  logic [NREQ*NB-1:0]     req_b,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [2*NB-1:0]        result,
  output logic                   busy,
  output logic                   err,
  output logic                   mul_start,
  output logic [NB-1:0]          mul_a,
  output logic [NB-1:0]          mul_b,
  input  logic [2*NB-1:0]        mul_product,
  input  logic                   mul_ready
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic [NREQ-1:0] win_oh;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;

  assign busy    = (state != S_IDLE);
  assign tmo_hit = (tmo_cnt == TW'(TMO - 1));

  // Round-robin pick: first set request scanning upward from ptr+1 with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = PW'((32'(ptr) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // One-hot form of the winner index.
  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; ready is deliberately not looked at in START since it
  // may still be high from the previous product.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (win_found) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (mul_ready || tmo_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant, operand latch, start pulse, timeout counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      ptr       <= PW'(NREQ - 1);
      tmo_cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt       <= win_oh;
            mul_a     <= req_a[32'(win_idx)*NB +: NB];
            mul_b     <= req_b[32'(win_idx)*NB +: NB];
            mul_start <= 1'b1;
            ptr       <= win_idx;
          end
        end
        S_START: begin
          mul_start <= 1'b0;
          tmo_cnt   <= '0;
        end
        S_WAIT: begin
          if (mul_ready) begin
            result <= mul_product;
            done   <= gnt;
          end else if (tmo_hit) begin
            err    <= 1'b1;
            result <= '0;
            done   <= gnt;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          gnt  <= '0;
          done <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
